// File: rtl/wingen_pkg.sv
// Shared types and defaults for the 3x3 sliding-window generator.
package wingen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } state_e;

    localparam int DEFAULT_IMG_W = 640;
    localparam int DEFAULT_IMG_H = 480;
    localparam int PIX_W         = 8;

endpackage

// File: rtl/window_gen_3x3_line_buf.sv
// One image line of pixel storage: synchronous write, combinational read at the same address.
module line_buf #(
    parameter  int DEPTH = 640,
    parameter  int DW    = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[addr_i];

endmodule

// File: rtl/window_gen_3x3.sv
// Raster-scan 3x3 window generator built on two line buffers and a 3x3 shift register.
// Optional frame_done output is enabled with the WINGEN_FRAME_DONE_EN macro.
module window_gen_3x3
    import wingen_pkg::*;
#(
    parameter int IMG_W = DEFAULT_IMG_W,
    parameter int IMG_H = DEFAULT_IMG_H
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_valid,
    input  logic             pix_sof,
    input  logic [PIX_W-1:0] pix_in,
    output logic [PIX_W-1:0] window00,
    output logic [PIX_W-1:0] window01,
    output logic [PIX_W-1:0] window02,
    output logic [PIX_W-1:0] window10,
    output logic [PIX_W-1:0] window11,
    output logic [PIX_W-1:0] window12,
    output logic [PIX_W-1:0] window20,
    output logic [PIX_W-1:0] window21,
    output logic [PIX_W-1:0] window22,
    output logic             start_conv,
`ifdef WINGEN_FRAME_DONE_EN
    output logic             frame_done,
`endif
    output logic             busy
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [PIX_W-1:0] win_q [3][3];
    logic [PIX_W-1:0] win_d [3][3];
    logic             start_conv_q, start_conv_d;

    logic             accept;
    logic [CW-1:0]    col_eff;
    logic [RW-1:0]    row_eff;
    logic [PIX_W-1:0] a_rd, b_rd;

    // A start-of-frame pixel always lands at (0,0), whatever the counters say.
    assign accept  = pix_valid && (pix_sof || (state_q != IDLE));
    assign col_eff = pix_sof ? '0 : col_q;
    assign row_eff = pix_sof ? '0 : row_q;

    line_buf #(.DEPTH(IMG_W), .DW(PIX_W)) u_line_a (
        .clk     (clk),
        .we_i    (accept),
        .addr_i  (col_eff),
        .wdata_i (pix_in),
        .rdata_o (a_rd)
    );

    line_buf #(.DEPTH(IMG_W), .DW(PIX_W)) u_line_b (
        .clk     (clk),
        .we_i    (accept),
        .addr_i  (col_eff),
        .wdata_i (a_rd),
        .rdata_o (b_rd)
    );

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        start_conv_d = 1'b0;
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2]  = b_rd;
            win_d[1][2]  = a_rd;
            win_d[2][2]  = pix_in;
            start_conv_d = (row_eff >= RW'(2)) && (col_eff >= CW'(2));
            if (col_eff == COL_LAST) begin
                col_d = '0;
                row_d = row_eff + 1'b1;
            end else begin
                col_d = col_eff + 1'b1;
                row_d = row_eff;
            end
            if (pix_sof) begin
                state_d = FILL;
            end else begin
                case (state_q)
                    FILL: begin
                        if ((row_eff == RW'(1)) && (col_eff == COL_LAST)) begin
                            state_d = STREAM;
                        end
                    end
                    STREAM: begin
                        if ((row_eff == ROW_LAST) && (col_eff == COL_LAST)) begin
                            state_d = IDLE;
                            col_d   = '0;
                            row_d   = '0;
                        end
                    end
                    default: state_d = state_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            start_conv_q <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            start_conv_q <= start_conv_d;
            win_q        <= win_d;
        end
    end

`ifdef WINGEN_FRAME_DONE_EN
    logic frame_done_q, frame_done_d;

    assign frame_done_d = start_conv_d && (row_eff == ROW_LAST) && (col_eff == COL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= frame_done_d;
        end
    end

    assign frame_done = frame_done_q;
`endif

    assign start_conv = start_conv_q;
    assign busy       = (state_q != IDLE);

    assign window00 = win_q[0][0];
    assign window01 = win_q[0][1];
    assign window02 = win_q[0][2];
    assign window10 = win_q[1][0];
    assign window11 = win_q[1][1];
    assign window12 = win_q[1][2];
    assign window20 = win_q[2][0];
    assign window21 = win_q[2][1];
    assign window22 = win_q[2][2];

endmodule

// File: doc/window_gen_3x3.md
WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

Interface
REQ-001 SHALL have parameter IMG_W, default 640, pixels per line (min 3).
REQ-002 SHALL have parameter IMG_H, default 480, lines per frame (min 3).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port pix_valid  input  1  pixel present on pix_in this cycle.
REQ-006 SHALL have port pix_sof  input  1  qualifies pixel (0,0) of a frame; meaningful only with pix_valid.
REQ-007 SHALL have port pix_in  input  8  unsigned grey pixel, raster order.
REQ-008 SHALL have ports window00..window22  output  8 each  3x3 window; row index 0 = oldest line, column index 0 = leftmost.
REQ-009 SHALL have port start_conv  output  1  one-cycle pulse: window outputs hold a new valid window.
REQ-010 SHALL have port busy  output  1  high in FILL or STREAM.

Function
REQ-011 SHALL implement FSM IDLE, FILL, STREAM; reset state IDLE.
REQ-012 IDLE: pixels without pix_sof ignored; pix_valid&pix_sof -> accept as (row0,col0), go FILL.
REQ-013 FILL covers rows 0-1; at the accept of pixel (1,IMG_W-1) -> STREAM.
REQ-014 STREAM covers rows 2..IMG_H-1; at the accept of pixel (IMG_H-1,IMG_W-1) -> IDLE.
REQ-015 col counter SHALL wrap IMG_W-1 -> 0 and increment row; widths $clog2(IMG_W), $clog2(IMG_H).
REQ-016 Each accepted pixel at column c SHALL write pix_in to line buffer A[c] and the old A[c] to B[c] in the same cycle (A = previous line, B = line before).
REQ-017 The window shift register SHALL shift left one column per accepted pixel; new right column = {B[c], A[c], pix_in} for rows {0,1,2}.
REQ-018 start_conv SHALL pulse the cycle after accepting pixel (r,c) with r>=2 and c>=2; latency exactly 1 cycle.
REQ-019 At that pulse, windowRC SHALL equal pixel (r-2+R, c-2+C).
REQ-020 Each frame SHALL produce exactly (IMG_W-2)*(IMG_H-2) start_conv pulses; none for c<2 or r<2.
REQ-021 pix_valid low cycles (gaps) SHALL freeze all counters, buffers and window; start_conv low.
REQ-022 Window outputs SHALL hold their value between pulses.
REQ-023 pix_sof with pix_valid in FILL/STREAM SHALL abort the frame: the pixel is taken as (0,0), state FILL, no pulse for that cycle.
REQ-024 No backpressure: the downstream stage accepts one window per cycle.

Reset
REQ-025 rst_n low SHALL force state IDLE, counters 0, start_conv 0, busy 0, windows 0 immediately (asynchronous).
REQ-026 Line buffer contents need not reset; they are never emitted before being rewritten in a new frame.
REQ-027 Reset mid-frame SHALL discard the frame; the next frame requires pix_sof.

Configuration
REQ-028 Macro WINGEN_FRAME_DONE_EN defined: extra output frame_done (1 bit, reset 0) SHALL pulse together with the last start_conv of a frame.
REQ-029 Without WINGEN_FRAME_DONE_EN: no frame_done port and no related logic.

Structure
REQ-030 Package wingen_pkg SHALL hold the FSM state enum (IDLE, FILL, STREAM) and the default IMG_W/IMG_H constants.
REQ-031 Sub-module line_buf (depth IMG_W, 8-bit, synchronous write, combinational read) SHALL be instantiated twice (A, B).

Verification
REQ-032 IMG_W=5, IMG_H=4, pixel=row*16+col, continuous valid -> first start_conv the cycle after (2,2), window00..22 = 00,01,02,10,11,12,20,21,22; 6 pulses total.
REQ-033 Same frame with random pix_valid gaps -> identical window sequence, 6 pulses, no pulse in a gap cycle.
REQ-034 pix_sof at (2,3) of frame 1, then full frame 2 -> no pulse for that pixel; the next pulses come from frame-2 data only.
REQ-035 rst_n low at (3,1) -> all outputs 0 asynchronously; pixels without sof are ignored afterwards.
REQ-036 Back-to-back frames (sof the cycle after the last pixel) -> 12 pulses; with WINGEN_FRAME_DONE_EN, frame_done on the 6th and 12th pulses only.
